// File: rtl/clock_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_div_pkg
// Description : Shared constants and helpers for the programmable clock
//               divider (mode encodings, default sizing, select width).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_div_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DEF_CNT_W = 26;
  localparam int DEF_DIV   = 50_000_000;

  // Width of the channel-select field; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : clock_div_pkg
`default_nettype wire

// File: rtl/clock_divider_prog_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_divider_prog_if
// Description : Control/output bundle of the programmable clock divider.
//               master = controlling logic, slave = divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_divider_prog_if
  import clock_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = ch_width(NUM_CH);

  logic              enable;
  logic              div_load;
  logic [CH_W-1:0]   ch_sel;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output enable, div_load, ch_sel, div_value, mode,
    input  clock_out, tick
  );

  modport slave (
    input  enable, div_load, ch_sel, div_value, mode,
    output clock_out, tick
  );

endinterface : clock_divider_prog_if
`default_nettype wire

// File: rtl/clock_div_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_div_channel
// Description : One divider channel: half-period counter, programmable divide
//               register, registered tick and square/pulse clock output.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             sync,
  input  wire logic             enable,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_value,
  input  wire logic             mode,
  output logic                  clock_out,
  output logic                  tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             terminal;

  // Counter never passes div-1, and div is never zero, so no wrap is possible.
  assign terminal = (cnt == (div - CNT_W'(1)));

  // Priority: reset > sync > load > counting; disabled channels freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div       <= CNT_W'(DEFAULT_DIV);
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (sync) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (load) begin
      div  <= (load_value == '0) ? CNT_W'(1) : load_value;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (terminal) begin
        cnt       <= '0;
        tick      <= 1'b1;
        clock_out <= (mode == MODE_PULSE) ? 1'b1 : ~clock_out;
      end else begin
        cnt       <= cnt + CNT_W'(1);
        tick      <= 1'b0;
        clock_out <= (mode == MODE_PULSE) ? 1'b0 : clock_out;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule : clock_div_channel
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clock_divider_prog
// Description : Multi-channel run-time programmable clock divider. Decodes
//               the load select and fans out the optional phase-align strobe.
//               Optional feature macro: CLKDIV_SYNC_EN (adds sync_all input).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_prog
  import clock_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  wire logic            clock_in,
  input  wire logic            reset,
`ifdef CLKDIV_SYNC_EN
  input  wire logic            sync_all,
`endif
  clock_divider_prog_if.slave  bus
);

  logic sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_all;
`else
  assign sync_w = 1'b0;
`endif

  // An out-of-range ch_sel matches no channel, so the load is dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic load_ch;
    assign load_ch = bus.div_load && (int'(bus.ch_sel) == c);

    clock_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clock_in),
      .rst        (reset),
      .sync       (sync_w),
      .enable     (bus.enable),
      .load       (load_ch),
      .load_value (bus.div_value),
      .mode       (bus.mode[c]),
      .clock_out  (bus.clock_out[c]),
      .tick       (bus.tick[c])
    );
  end

endmodule : clock_divider_prog
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider_prog
// Description : Scoreboard bench for clock_divider_prog (2 channels, CNT_W 8,
//               DEFAULT_DIV 5) plus a 3-channel instance for out-of-range
//               channel selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_prog;

  logic clock_in = 1'b0;
  logic reset;
  logic sync_all;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int   cyc;
    logic lvl;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  clock_divider_prog_if #(.NUM_CH(2), .CNT_W(8)) bus ();
  clock_divider_prog_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

  clock_divider_prog #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clock_in (clock_in),
    .reset    (reset),
`ifdef CLKDIV_SYNC_EN
    .sync_all (sync_all),
`endif
    .bus      (bus)
  );

  clock_divider_prog #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(5)) dut3 (
    .clock_in (clock_in),
    .reset    (reset),
`ifdef CLKDIV_SYNC_EN
    .sync_all (1'b0),
`endif
    .bus      (bus3)
  );

  always #10 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    goto(n);
    @(negedge clock_in);
  endtask

  task automatic exp0(input int c, input logic l);
    ev_t e;
    e.cyc = c; e.lvl = l;
    q0.push_back(e);
  endtask

  task automatic exp1(input int c, input logic l);
    ev_t e;
    e.cyc = c; e.lvl = l;
    q1.push_back(e);
  endtask

  // Monitor: every observed tick must match the next expected event.
  always @(negedge clock_in) begin
    ev_t e;
    if (bus.tick[0] === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL tick0_unexpected at cycle %0d: got tick, expected none", cyc);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || e.lvl !== bus.clock_out[0]) begin
          n_fail++;
          $display("FAIL tick0 event: got cycle %0d level %b, expected cycle %0d level %b",
                   cyc, bus.clock_out[0], e.cyc, e.lvl);
        end
      end
    end
    if (bus.tick[1] === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL tick1_unexpected at cycle %0d: got tick, expected none", cyc);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.lvl !== bus.clock_out[1]) begin
          n_fail++;
          $display("FAIL tick1 event: got cycle %0d level %b, expected cycle %0d level %b",
                   cyc, bus.clock_out[1], e.cyc, e.lvl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int end_cyc;
    reset = 1'b1; sync_all = 1'b0;
    bus.enable = 1'b0; bus.div_load = 1'b0; bus.ch_sel = '0; bus.div_value = '0; bus.mode = '0;
    bus3.enable = 1'b0; bus3.div_load = 1'b0; bus3.ch_sel = '0; bus3.div_value = '0; bus3.mode = '0;

    at_neg(3);
    chk("reset_clock_out", 8'(bus.clock_out), 8'h0);
    chk("reset_tick", 8'(bus.tick), 8'h0);
    chk("reset_tick3", 8'(bus3.tick), 8'h0);

    // Release: both channels square, div 5, first tick 5 edges later.
    reset = 1'b0; bus.enable = 1'b1; bus3.enable = 1'b1;
    exp0(8, 1); exp0(13, 0); exp0(18, 1); exp0(23, 0); exp0(28, 1); exp0(33, 0); exp0(38, 1);
    exp1(8, 1); exp1(13, 0); exp1(18, 1);

    // Channel 1 to pulse mode.
    goto(18);
    bus.mode = 2'b10;
    exp1(23, 1); exp1(28, 1);
    at_neg(20);
    chk("pulse_low_between_ticks", 8'(bus.clock_out[1]), 8'h0);

    // Mid-period reload of ch1 to 3; out-of-range load on the 3-ch instance.
    goto(30);
    bus.div_load = 1'b1; bus.ch_sel = 1'b1; bus.div_value = 8'd3;
    bus3.div_load = 1'b1; bus3.ch_sel = 2'd3; bus3.div_value = 8'd1;
    exp1(34, 1); exp1(37, 1); exp1(40, 1); exp1(43, 1); exp1(46, 1); exp1(49, 1);
    goto(31);
    bus.div_load = 1'b0; bus3.div_load = 1'b0;
    at_neg(33);
    chk("bad_sel_tick_a", 8'(bus3.tick), 8'h7);
    at_neg(34);
    chk("bad_sel_quiet", 8'(bus3.tick), 8'h0);
    at_neg(38);
    chk("bad_sel_tick_b", 8'(bus3.tick), 8'h7);

    // Zero divide value on ch0 clamps to 1: toggle every cycle.
    goto(40);
    bus.div_load = 1'b1; bus.ch_sel = 1'b0; bus.div_value = 8'd0;
    exp0(42, 0); exp0(43, 1); exp0(44, 0); exp0(45, 1); exp0(46, 0);
    goto(41);
    bus.div_load = 1'b0;

    // Back to div 5, then pause at count 2 for 7 cycles.
    goto(46);
    bus.div_load = 1'b1; bus.ch_sel = 1'b0; bus.div_value = 8'd5;
    goto(47);
    bus.div_load = 1'b0;
    goto(49);
    bus.enable = 1'b0;
    exp0(59, 1); exp1(59, 1);
    for (int n = 50; n <= 56; n++) begin
      at_neg(n);
      chk("frozen_tick", 8'(bus.tick), 8'h0);
      chk("frozen_clock_out0", 8'(bus.clock_out[0]), 8'h0);
    end
    bus.enable = 1'b1;

    // Reset while ch0 is high and mid-count; mode back to square.
    goto(61);
    reset = 1'b1; bus.mode = 2'b00;
    at_neg(62);
    chk("mid_reset_clock_out", 8'(bus.clock_out), 8'h0);
    chk("mid_reset_tick", 8'(bus.tick), 8'h0);
    reset = 1'b0;
    exp0(67, 1); exp1(67, 1);

`ifdef CLKDIV_SYNC_EN
    goto(69);
    bus.div_load = 1'b1; bus.ch_sel = 1'b1; bus.div_value = 8'd5;
    goto(70);
    bus.div_load = 1'b0;
    goto(71);
    sync_all = 1'b1;
    goto(72);
    sync_all = 1'b0;
    exp0(77, 1); exp1(77, 1);
    @(negedge clock_in);
    chk("sync_clock_out", 8'(bus.clock_out), 8'h0);
    end_cyc = 80;
`else
    end_cyc = 70;
`endif

    at_neg(end_cyc);
    chk("missing_ticks_ch0", 8'(q0.size()), 8'h0);
    chk("missing_ticks_ch1", 8'(q1.size()), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clock_divider_prog
`default_nettype wire
